pipeline_ctrl: RTL
==================

# pipeline_ctrl

Control block for the 5-stage MIPS front end: it drives the PC write enable, the IF/ID register hold and clear, and the ID/EX bubble insert. It detects load-use hazards, sequences branch redirects across a slow instruction memory, and implements a HALT/resume state for the debug unit. It sits beside the IF/ID register and consumes decode and EX-stage status only.

## Interface
- REG_W, 5: register-specifier width.
- STAT_W, 16: statistics counter width (used only with the stats macro).

- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- id_ex_memread  in  1  instruction in EX is a load.
- id_ex_rt  in  REG_W  load destination register.
- if_id_rs  in  REG_W  rs of the instruction in ID.
- if_id_rt  in  REG_W  rt of the instruction in ID.
- if_id_uses_rt  in  1  instruction in ID reads rt as a source.
- branch_taken  in  1  taken branch or jump resolved in EX this cycle.
- halt_req  in  1  HALT instruction decoded in ID.
- resume  in  1  single-cycle pulse from the debug unit.
- imem_ready  in  1  instruction memory presents a valid word this cycle.
- pc_write  out  1  PC register loads this cycle.
- if_id_le  out  1  1 = IF/ID holds its contents (latch closed).
- if_id_clear  out  1  IF/ID loads a NOP and keeps PC+4.
- id_ex_clear  out  1  ID/EX loads a bubble.
- halted  out  1  in HALT state.
- stall_cycles  out  STAT_W  stats only.
- flush_count  out  STAT_W  stats only.

## Operation
- hazard = id_ex_memread & (id_ex_rt != 0) & ((id_ex_rt == if_id_rs) | (if_id_uses_rt & id_ex_rt == if_id_rt)).
- Default outputs are pc_write=1 and all others 0.
- States: RUN, FLUSH, HALT. The encoding is in the package.
- RUN priority, highest first:
  - branch_taken: if_id_clear=1, id_ex_clear=1, pc_write=1 (loads target). Next state FLUSH.
  - halt_req: pc_write=0, if_id_le=1, id_ex_clear=1. Next state HALT.
  - hazard: pc_write=0, if_id_le=1, id_ex_clear=1. Stay in RUN, giving a one-cycle bubble that repeats while hazard holds.
  - !imem_ready: pc_write=0, if_id_clear=1. Stay in RUN.
- FLUSH: pc_write=0, if_id_clear=1, id_ex_clear=0.
  - Exit to RUN on the first cycle with imem_ready=1. That cycle still clears IF/ID and holds the PC.
  - Minimum dwell is 1 cycle.
  - branch_taken and halt_req are ignored here, because the pipe ahead holds only bubbles.
- HALT: pc_write=0, if_id_le=1, id_ex_clear=1, halted=1.
  - resume moves to RUN. halt_req is masked for that first RUN cycle, so the HALT instruction, which was held in IF/ID, is replaced by advancing past it.
  - branch_taken, hazard, and imem_ready are ignored while in HALT.
- Simultaneous branch_taken with hazard or halt_req: branch wins, and the younger instructions are discarded.

## Timing
- State is registered. Outputs are combinational from state and current inputs, with zero-cycle latency to the datapath enables.
- Reset (synchronous, takes effect at the clock edge while asserted):
  - state goes to RUN and counters go to 0.
  - While reset is high, outputs are forced to pc_write=0, if_id_le=0, if_id_clear=1, id_ex_clear=1, halted=0.
- Reset mid-FLUSH or mid-HALT returns to RUN the next cycle. No resume is needed.
- Branch redirect costs at least 2 bubbles: the detection cycle plus at least 1 FLUSH cycle. Each extra imem wait adds 1.
- A load-use stall costs exactly 1 cycle per hazard instance.

## Configuration
- PIPE_CTRL_STATS_EN defined:
  - stall_cycles increments every non-reset cycle with pc_write=0.
  - flush_count increments on every RUN-state branch_taken.
  - Both counters saturate at all-ones and clear only on reset.
- Not defined: both ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package mips_pipe_pkg holds:
  - the state enum (RUN, FLUSH, HALT)
  - the REG_W default
  - the NOP instruction constant shared with IF/ID
- One sub-module, hazard_detect: the purely combinational load-use compare, which produces hazard.
- The FSM and the stats counters stay in pipeline_ctrl.

## Test plan
- Load-use on rs: id_ex_memread=1, id_ex_rt=8, if_id_rs=8 for one cycle -> exactly one cycle of pc_write=0, if_id_le=1, id_ex_clear=1. With id_ex_rt=0 -> no stall.
- Load-use on rt: the same compare with if_id_uses_rt=0 gives no stall; with if_id_uses_rt=1 it stalls one cycle.
- Branch with imem_ready low for 3 cycles after the redirect -> if_id_clear high for 4 cycles (detect + 3 FLUSH waits) plus 1 exit cycle, pc_write high only in the detect cycle, and flush_count=1.
- branch_taken and halt_req asserted together -> branch path taken, halted stays 0, and the next state is FLUSH.
- halt_req, then 10 idle cycles, then a resume pulse -> halted=1 for exactly those cycles, pc_write=0 throughout, and RUN resumes the cycle after resume.
- reset asserted for one cycle while in HALT -> the next cycle is RUN with halted=0, and stall_cycles=0 when stats are enabled.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline control slice.
package mips_pipe_pkg;

  localparam int unsigned REG_W_DEF  = 5;
  localparam int unsigned STAT_W_DEF = 16;
  localparam int unsigned INSTR_W    = 32;

  // sll $0,$0,0 -- loaded into IF/ID when it is cleared
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use hazard compare between the load in EX and the instruction in ID.
module hazard_detect
  import mips_pipe_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF
) (
  input  logic             id_ex_memread,
  input  logic [REG_W-1:0] id_ex_rt,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             if_id_uses_rt,
  output logic             hazard_c
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = (id_ex_rt == if_id_rs);
    rt_match = if_id_uses_rt & (id_ex_rt == if_id_rt);
    // $0 is never a real dependency
    hazard_c = id_ex_memread & (id_ex_rt != '0) & (rs_match | rt_match);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Front-end pipeline control: load-use stall, branch redirect flush, debug HALT.
// Optional statistics counters are built when PIPE_CTRL_STATS_EN is defined.
module pipeline_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF
`ifdef PIPE_CTRL_STATS_EN
  , parameter int unsigned STAT_W = STAT_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_ex_memread,
  input  logic [REG_W-1:0] id_ex_rt,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             if_id_uses_rt,
  input  logic             branch_taken,
  input  logic             halt_req,
  input  logic             resume,
  input  logic             imem_ready,
  output logic             pc_write,
  output logic             if_id_le,
  output logic             if_id_clear,
  output logic             id_ex_clear,
  output logic             halted
`ifdef PIPE_CTRL_STATS_EN
  , output logic [STAT_W-1:0] stall_cycles
  , output logic [STAT_W-1:0] flush_count
`endif
);

  ctrl_state_e state_q, state_d;
  logic        halt_mask_q;
  logic        hazard;
  logic        run_branch_c;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .id_ex_memread (id_ex_memread),
    .id_ex_rt      (id_ex_rt),
    .if_id_rs      (if_id_rs),
    .if_id_rt      (if_id_rt),
    .if_id_uses_rt (if_id_uses_rt),
    .hazard_c      (hazard)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      halt_mask_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      // mask halt_req only in the first RUN cycle after resume
      halt_mask_q <= (state_q == ST_HALT) & resume;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_write     = 1'b1;
    if_id_le     = 1'b0;
    if_id_clear  = 1'b0;
    id_ex_clear  = 1'b0;
    halted       = 1'b0;
    run_branch_c = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (branch_taken) begin
          run_branch_c = 1'b1;
          if_id_clear  = 1'b1;
          id_ex_clear  = 1'b1;
          state_d      = ST_FLUSH;
        end else if (halt_req && !halt_mask_q) begin
          pc_write    = 1'b0;
          if_id_le    = 1'b1;
          id_ex_clear = 1'b1;
          state_d     = ST_HALT;
        end else if (hazard) begin
          pc_write    = 1'b0;
          if_id_le    = 1'b1;
          id_ex_clear = 1'b1;
        end else if (!imem_ready) begin
          pc_write    = 1'b0;
          if_id_clear = 1'b1;
        end
      end
      ST_FLUSH: begin
        pc_write    = 1'b0;
        if_id_clear = 1'b1;
        if (imem_ready) state_d = ST_RUN;
      end
      ST_HALT: begin
        pc_write    = 1'b0;
        if_id_le    = 1'b1;
        id_ex_clear = 1'b1;
        halted      = 1'b1;
        if (resume) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    if (reset) begin
      pc_write     = 1'b0;
      if_id_le     = 1'b0;
      if_id_clear  = 1'b1;
      id_ex_clear  = 1'b1;
      halted       = 1'b0;
      run_branch_c = 1'b0;
    end
  end

`ifdef PIPE_CTRL_STATS_EN
  // saturating event counters, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_write && (stall_cycles != '1)) stall_cycles <= stall_cycles + STAT_W'(1);
      if (run_branch_c && (flush_count != '1)) flush_count <= flush_count + STAT_W'(1);
    end
  end
`endif

endmodule
